fifo_hs: RTL and testbench
==========================

FIFO_HS -- requirements
Module: fifo_hs

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, >=2.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2, almost_full level threshold (1..DEPTH).
REQ-004 SHALL have parameter AE_THRESH, default 2, almost_empty level threshold (0..DEPTH-1).
REQ-005 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port flush  input  1  synchronous discard of all contents.
REQ-008 SHALL have ports s_valid input 1, s_ready output 1, s_data input DATA_WIDTH: write-side handshake.
REQ-009 SHALL have ports m_valid output 1, m_ready input 1, m_data output DATA_WIDTH: read-side handshake, first-word-fall-through.
REQ-010 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy 0..DEPTH.
REQ-011 SHALL have ports almost_full output 1 and almost_empty output 1: threshold flags.
REQ-012 SHALL have port peak_level  output  $clog2(DEPTH)+1  high-watermark; present only under FIFO_HS_STATS_EN.

Function
REQ-013 SHALL use read/write pointers of $clog2(DEPTH)+1 bits: low bits index storage, MSB is the wrap bit.
REQ-014 SHALL drive empty when pointers are equal, and full when the MSBs differ and the low bits are equal.
REQ-015 SHALL drive s_ready = !full, m_valid = !empty, both purely from registered pointers, independent of s_valid/m_ready.
REQ-016 SHALL push s_data on a cycle where s_valid && s_ready, and pop on a cycle where m_valid && m_ready.
REQ-017 SHALL present m_data = entry at the read pointer combinationally; it is undefined (don't care) while m_valid=0.
REQ-018 SHALL give write-to-m_valid latency of one cycle when empty; no same-cycle bypass.
REQ-019 SHALL perform push and pop together when both occur; level is then unchanged.
REQ-020 SHALL reject pushes when full even if a pop occurs in the same cycle (s_ready stays 0).
REQ-021 SHALL hold m_data and m_valid stable while m_valid=1 and m_ready=0.
REQ-022 SHALL compute level = wr_ptr - rd_ptr modulo 2^($clog2(DEPTH)+1), correct across pointer wrap.
REQ-023 SHALL drive almost_full = (level >= AF_THRESH) and almost_empty = (level <= AE_THRESH), both combinational from level.
REQ-024 SHALL, on flush=1, zero both pointers at the next edge, overriding any push or pop in that cycle; storage contents are not cleared.

Reset
REQ-025 SHALL, while rst_n=0, hold both pointers at 0, giving level=0, m_valid=0, s_ready=1, almost_empty=1 and almost_full=0.
REQ-026 SHALL abandon all contents on reset mid-operation, with storage left uninitialised.
REQ-027 SHALL reset peak_level to 0 when present.

Configuration
REQ-028 SHALL, with macro FIFO_HS_STATS_EN defined, register peak_level = max(peak_level, level), updated every cycle and cleared to 0 by flush.
REQ-029 SHALL, without FIFO_HS_STATS_EN, omit the peak_level port and its register entirely; all other behaviour is identical.

Structure
REQ-030 SHALL place a pointer/level width function and shared FIFO constants in package fifo_pkg.
REQ-031 SHALL put storage in sub-module fifo_hs_mem: DEPTH x DATA_WIDTH, one synchronous write port, one asynchronous read port, no reset.

Verification (DEPTH=4, DATA_WIDTH=8, AF_THRESH=3, AE_THRESH=1)
REQ-032 SHALL check: push 0x11,0x22,0x33,0x44 with m_ready=0 -> s_ready=0 after 4th push, level=4, almost_full=1; 5th push 0x55 not stored.
REQ-033 SHALL check: drain the full FIFO with m_ready=1 -> m_data sequence 0x11,0x22,0x33,0x44, then m_valid=0, level=0, almost_empty=1.
REQ-034 SHALL check: continuous push+pop for 10 cycles at level 2 -> level stays 2, data in order across pointer wrap.
REQ-035 SHALL check: push 0xA5 into an empty FIFO -> m_valid=1 and m_data=0xA5 exactly one cycle later.
REQ-036 SHALL check: flush asserted with s_valid=1 at level 3 -> next cycle level=0, m_valid=0, pushed word discarded; under FIFO_HS_STATS_EN peak_level=0.
REQ-037 SHALL check: rst_n pulsed low mid-stream at level 2 -> outputs take reset values asynchronously, and the first push after reset is the first word read.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO constants and the pointer/level width helper.
`default_nettype none

package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;

  // Pointers carry one extra wrap bit above the storage index.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_hs_mem.sv
// fifo_hs_mem: DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read, no reset.
`default_nettype none

module fifo_hs_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(DEPTH)-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0]      raddr,
  output logic [DATA_WIDTH-1:0]         rdata
);

  localparam int ADDR_W = ptr_width(DEPTH) - 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr[ADDR_W-1:0]];

endmodule

`default_nettype wire

// File: rtl/fifo_hs.sv
// fifo_hs: first-word-fall-through handshake FIFO with level and threshold flags.
// Optional high-watermark output peak_level enabled by macro FIFO_HS_STATS_EN.
`default_nettype none

module fifo_hs
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_WIDTH-1:0]    s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     almost_empty
`ifdef FIFO_HS_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]   peak_level
`endif
);

  localparam int               PTR_W    = ptr_width(DEPTH);
  localparam int               ADDR_W   = PTR_W - 1;
  localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] AE_LEVEL = PTR_W'(AE_THRESH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign s_ready = !full;
  assign m_valid = !empty;
  assign push    = s_valid && !full;
  assign pop     = m_ready && !empty;

  // Flush wins over any handshake in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  assign level        = wr_ptr - rd_ptr;
  assign almost_full  = (level >= AF_LEVEL);
  assign almost_empty = (level <= AE_LEVEL);

  fifo_hs_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (s_data),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (m_data)
  );

`ifdef FIFO_HS_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_level <= '0;
    end else if (flush) begin
      peak_level <= '0;
    end else if (level > peak_level) begin
      peak_level <= level;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_hs.sv
// tb_fifo_hs: directed and randomized checks of fifo_hs against a queue-based model.
`default_nettype none

module tb_fifo_hs;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [2:0]    level;
  logic          almost_full;
  logic          almost_empty;
`ifdef FIFO_HS_STATS_EN
  logic [2:0]    peak_level;
`endif

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  fifo_hs #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (3),
    .AE_THRESH  (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`ifdef FIFO_HS_STATS_EN
    ,
    .peak_level   (peak_level)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the FIFO is just a queue of accepted words.
  logic [DW-1:0] q[$];
  int            peak = 0;
  int            m_sz;
  bit            m_pu;
  bit            m_po;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      peak = 0;
    end else begin
      m_sz = q.size();
      m_pu = s_valid && (m_sz < DEPTH);
      m_po = m_ready && (m_sz > 0);
      if (flush) begin
        q.delete();
        peak = 0;
      end else begin
        if (m_sz > peak) peak = m_sz;
        if (m_po) void'(q.pop_front());
        if (m_pu) q.push_back(s_data);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("level",        int'(level),        q.size());
      check("m_valid",      int'(m_valid),      int'(q.size() > 0));
      check("s_ready",      int'(s_ready),      int'(q.size() < DEPTH));
      check("almost_full",  int'(almost_full),  int'(q.size() >= 3));
      check("almost_empty", int'(almost_empty), int'(q.size() <= 1));
      if (q.size() > 0) check("m_data", int'(m_data), int'(q[0]));
`ifdef FIFO_HS_STATS_EN
      check("peak_level",   int'(peak_level),   peak);
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [DW-1:0] exp_seq [4];

  initial begin
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33; exp_seq[3] = 8'h44;

    repeat (3) tick();
    check("rst_level",   int'(level),        0);
    check("rst_s_ready", int'(s_ready),      1);
    check("rst_m_valid", int'(m_valid),      0);
    check("rst_ae",      int'(almost_empty), 1);
    check("rst_af",      int'(almost_full),  0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Fill to full, then an extra push that must be refused.
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = exp_seq[i];
      tick();
    end
    check("full_s_ready", int'(s_ready),     0);
    check("full_level",   int'(level),       4);
    check("full_af",      int'(almost_full), 1);
    s_data = 8'h55;
    tick();
    check("full_reject_level", int'(level), 4);
    s_valid = 1'b0;

    // Drain in order.
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", int'(m_valid), 1);
      check("drain_data",  int'(m_data),  int'(exp_seq[i]));
      tick();
    end
    check("drain_m_valid", int'(m_valid),      0);
    check("drain_level",   int'(level),        0);
    check("drain_ae",      int'(almost_empty), 1);
    m_ready = 1'b0;

    // One-cycle write-to-read latency, no bypass.
    s_valid = 1'b1; s_data = 8'hA5;
    #1;
    check("lat_pre_valid", int'(m_valid), 0);
    tick();
    s_valid = 1'b0;
    check("lat_valid", int'(m_valid), 1);
    check("lat_data",  int'(m_data),  8'hA5);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;

    // Steady push+pop at level 2 across pointer wrap.
    s_valid = 1'b1;
    s_data = 8'h01; tick();
    s_data = 8'h02; tick();
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data = 8'(8'h03 + i);
      check("stream_data", int'(m_data), i + 1);
      tick();
      check("stream_level", int'(level), 2);
    end
    s_valid = 1'b0; m_ready = 1'b0;

    // Flush at level 3 discards a concurrent push.
    s_valid = 1'b1; s_data = 8'h0D; tick();
    check("pre_flush_level", int'(level), 3);
    flush = 1'b1; s_data = 8'hEE;
    tick();
    flush = 1'b0; s_valid = 1'b0;
    check("flush_level",   int'(level),   0);
    check("flush_m_valid", int'(m_valid), 0);
`ifdef FIFO_HS_STATS_EN
    check("flush_peak",    int'(peak_level), 0);
`endif
    tick();
    check("flush_discard_level", int'(level), 0);

    // Asynchronous reset mid-stream at level 2.
    s_valid = 1'b1;
    s_data = 8'h21; tick();
    s_data = 8'h22; tick();
    s_valid = 1'b0;
    check("pre_rst_level", int'(level), 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_level",   int'(level),        0);
    check("arst_m_valid", int'(m_valid),      0);
    check("arst_s_ready", int'(s_ready),      1);
    check("arst_ae",      int'(almost_empty), 1);
    check("arst_af",      int'(almost_full),  0);
    tick();
    rst_n = 1'b1;
    tick();
    s_valid = 1'b1;
    s_data = 8'h31; tick();
    s_data = 8'h32; tick();
    s_valid = 1'b0;
    check("post_rst_first", int'(m_data), 8'h31);

    // Randomized traffic with varying push/pop bias and occasional flush.
    for (int ph = 0; ph < 4; ph++) begin
      for (int n = 0; n < 500; n++) begin
        s_valid = ($urandom_range(0, 99) < 30 + 20 * ph);
        m_ready = ($urandom_range(0, 99) < 90 - 20 * ph);
        s_data  = 8'($urandom);
        flush   = ($urandom_range(0, 63) == 0);
        tick();
      end
    end
    s_valid = 1'b0; m_ready = 1'b0; flush = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
